// File: rtl/ccr_unit.sv
// Condition-code register: zf/cf/nf with masked ALU writes, SETC/CLRC,
// clear-on-taken-branch, and a LIFO shadow stack for interrupt save/restore.
// Ports: clk, rst_n (sync, active-low), stall; alu_zf/cf/nf + flag_we[2:0];
//   setc, clrc; br_taken, br_sel[1:0]; int_save, int_restore;
//   zf, cf, nf, stk_cnt, ovf_err, unf_err (all registered).
module ccr_unit #(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          alu_zf,
  input  logic          alu_cf,
  input  logic          alu_nf,
  input  logic [2:0]    flag_we,
  input  logic          setc,
  input  logic          clrc,
  input  logic          br_taken,
  input  logic [1:0]    br_sel,
  input  logic          int_save,
  input  logic          int_restore,
  output logic          zf,
  output logic          cf,
  output logic          nf,
  output logic [PW-1:0] stk_cnt,
  output logic          ovf_err,
  output logic          unf_err
);

  localparam logic [PW-1:0] FULL = PW'(DEPTH);
  // Sized to the pointer range so any pointer value indexes cleanly.
  localparam int SLOTS = 2 ** PW;

  // {zf, cf, nf}
  logic [2:0]    flags_q, flags_d;
  logic [2:0]    upd;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [2:0]    stk_q [SLOTS];
  logic [2:0]    stk_d [SLOTS];

  always_comb begin
    upd = flags_q;
    if (flag_we[2]) upd[2] = alu_zf;
    if (flag_we[1]) upd[1] = alu_cf;
    if (flag_we[0]) upd[0] = alu_nf;
    if (setc) upd[1] = 1'b1;
    if (clrc) upd[1] = 1'b0;
    if (br_taken) begin
      unique case (br_sel)
        2'b00: upd[2] = 1'b0;
        2'b01: upd[1] = 1'b0;
        2'b10: upd[0] = 1'b0;
        2'b11: ;
      endcase
    end
  end

  always_comb begin
    flags_d = flags_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stk_d   = stk_q;
    if (!stall) begin
      if (int_restore) begin
        if (cnt_q != '0) begin
          flags_d = stk_q[cnt_q - 1'b1];
          cnt_d   = cnt_q - 1'b1;
        end else begin
          unf_d = 1'b1;
        end
      end else begin
        flags_d = upd;
        // Push the pre-update flags; the update still lands this cycle.
        if (int_save) begin
          if (cnt_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            stk_d[cnt_q] = flags_q;
            cnt_d        = cnt_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents carry no reset value; the count alone marks validity.
  always_ff @(posedge clk) begin
    stk_q <= stk_d;
  end

  assign zf      = flags_q[2];
  assign cf      = flags_q[1];
  assign nf      = flags_q[0];
  assign stk_cnt = cnt_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Directed bench for ccr_unit (DEPTH=2).
// Observed vector: {zf,cf,nf,stk_cnt[1:0],ovf_err,unf_err}.
module tb_ccr_unit;

  logic       clk = 1'b0;
  logic       rst_n, stall;
  logic       alu_zf, alu_cf, alu_nf;
  logic [2:0] flag_we;
  logic       setc, clrc, br_taken;
  logic [1:0] br_sel;
  logic       int_save, int_restore;
  logic       zf, cf, nf, ovf_err, unf_err;
  logic [1:0] stk_cnt;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  ccr_unit #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_nf(alu_nf),
    .flag_we(flag_we), .setc(setc), .clrc(clrc),
    .br_taken(br_taken), .br_sel(br_sel),
    .int_save(int_save), .int_restore(int_restore),
    .zf(zf), .cf(cf), .nf(nf), .stk_cnt(stk_cnt),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  function automatic logic [6:0] obs();
    return {zf, cf, nf, stk_cnt, ovf_err, unf_err};
  endfunction

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] o;
    o = obs();
    ntests++;
    assert (o === exp) else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; stall = 1'b0;
    {alu_zf, alu_cf, alu_nf} = 3'b000;
    flag_we = 3'b000; setc = 1'b0; clrc = 1'b0;
    br_taken = 1'b0; br_sel = 2'b00;
    int_save = 1'b0; int_restore = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Write all three flags via the ALU path in one cycle.
  task automatic setf(input logic [2:0] f);
    idle();
    flag_we = 3'b111;
    {alu_zf, alu_cf, alu_nf} = f;
    cyc();
    idle();
  endtask

  initial begin
    idle();
    #1;
    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      {stall, alu_zf, alu_cf, alu_nf, setc, clrc} = 6'($urandom);
      flag_we = 3'($urandom);
      br_taken = 1'($urandom);
      br_sel = 2'($urandom);
      int_save = 1'($urandom);
      int_restore = 1'($urandom);
      rst_n = 1'b0;
      cyc();
      chk("reset", 7'b000_00_0_0);
    end
    idle();
    cyc();
    chk("post_reset_idle", 7'b000_00_0_0);

    setf(3'b111);
    chk("write_all", 7'b111_00_0_0);

    // Registered outputs: input change without a clock edge has no effect
    flag_we = 3'b111;
    {alu_zf, alu_cf, alu_nf} = 3'b000;
    br_taken = 1'b1;
    #2;
    chk("no_comb_path", 7'b111_00_0_0);
    idle();

    // Masked write, clrc beats setc
    setf(3'b000);
    chk("clear_all", 7'b000_00_0_0);
    flag_we = 3'b101;
    {alu_zf, alu_cf, alu_nf} = 3'b111;
    setc = 1'b1; clrc = 1'b1;
    cyc();
    idle();
    chk("mask_clrc_wins", 7'b101_00_0_0);

    setc = 1'b1;
    cyc();
    idle();
    chk("setc", 7'b111_00_0_0);

    // Branch clear beats ALU write
    br_taken = 1'b1; br_sel = 2'b00;
    flag_we = 3'b100; alu_zf = 1'b1;
    cyc();
    idle();
    chk("br_clear_zf", 7'b011_00_0_0);

    setf(3'b111);
    br_taken = 1'b1; br_sel = 2'b11;
    flag_we = 3'b100; alu_zf = 1'b1;
    cyc();
    idle();
    chk("br_sel_11", 7'b111_00_0_0);

    br_taken = 1'b1; br_sel = 2'b01; setc = 1'b1;
    cyc();
    idle();
    chk("br_clear_cf", 7'b101_00_0_0);

    setf(3'b111);
    br_taken = 1'b1; br_sel = 2'b10;
    cyc();
    idle();
    chk("br_clear_nf", 7'b110_00_0_0);

    // Nested save/restore, DEPTH=2
    setf(3'b100);
    int_save = 1'b1;
    cyc();
    idle();
    chk("save1", 7'b100_01_0_0);
    setf(3'b010);
    int_save = 1'b1;
    cyc();
    idle();
    chk("save2", 7'b010_10_0_0);
    setf(3'b001);
    int_save = 1'b1;
    cyc();
    idle();
    chk("save3_ovf", 7'b001_10_1_0);
    int_restore = 1'b1;
    cyc();
    chk("restore1", 7'b010_01_1_0);
    cyc();
    chk("restore2", 7'b100_00_1_0);
    // Restore ignores ALU write on the underflow cycle too
    flag_we = 3'b111;
    cyc();
    idle();
    chk("restore3_unf", 7'b100_00_1_1);

    // Save and update in the same cycle
    setf(3'b000);
    int_save = 1'b1;
    flag_we = 3'b010; alu_cf = 1'b1;
    cyc();
    idle();
    chk("save_update", 7'b010_01_1_1);
    int_restore = 1'b1;
    setc = 1'b1; int_save = 1'b1;
    cyc();
    idle();
    chk("restore_prev", 7'b000_00_1_1);

    // Stall freezes everything
    setf(3'b101);
    int_save = 1'b1;
    cyc();
    idle();
    chk("pre_stall", 7'b101_01_1_1);
    stall = 1'b1;
    int_save = 1'b1; int_restore = 1'b1;
    br_taken = 1'b1; br_sel = 2'b00;
    flag_we = 3'b111;
    {alu_zf, alu_cf, alu_nf} = 3'b010;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold", 7'b101_01_1_1);
    end
    stall = 1'b0; int_save = 1'b0;
    br_taken = 1'b0; flag_we = 3'b000;
    cyc();
    idle();
    chk("after_stall_restore", 7'b101_00_1_1);

    // Reset wins over stall
    stall = 1'b1; rst_n = 1'b0;
    cyc();
    idle();
    chk("reset_in_stall", 7'b000_00_0_0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/ccr_unit.md
# ccr_unit

Condition-code register for the pipeline. It holds the zero, carry and negative flags and drives them straight into the branch-decision logic, which consumes them alongside the branch select and branch control signals. The block applies masked ALU flag writes, the carry set/clear instructions, and the clear-on-taken-branch rule. It also keeps a small shadow stack so flags are saved on interrupt entry and restored on return.

## Interface
- DEPTH, 2, number of shadow-stack entries (≥1); pointer width is clog2(DEPTH+1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- stall  input  1  pipeline hold; freezes all state.
- alu_zf, alu_cf, alu_nf  input  1 each  flag values produced by the EX-stage ALU.
- flag_we  input  3  per-flag write mask from ALU: bit2=zf, bit1=cf, bit0=nf.
- setc  input  1  SETC instruction: force cf=1.
- clrc  input  1  CLRC instruction: force cf=0.
- br_taken  input  1  branch_out fed back from the branch-decision logic.
- br_sel  input  2  branch select of the taken branch: 00=zf, 01=cf, 10=nf, 11=unconditional.
- int_save  input  1  interrupt entry: push current flags.
- int_restore  input  1  RTI: pop flags.
- zf, cf, nf  output  1 each  registered flags, feeding the branch-decision logic.
- stk_cnt  output  clog2(DEPTH+1)  number of occupied shadow entries.
- ovf_err  output  1  sticky flag: push attempted while full.
- unf_err  output  1  sticky flag: pop attempted while empty.

## Operation
- The cycle is evaluated in strict priority order: reset, then stall, then restore, then normal update.
- **Reset** (rst_n=0 at a clock edge):
  - zf, cf, nf = 0; stk_cnt = 0; ovf_err = 0; unf_err = 0.
  - Stack contents are don't-care.
  - Reset overrides any in-progress save or restore.
- **Stall** (stall=1): every register holds. All other inputs are ignored, including int_save and int_restore.
- **Restore** (int_restore=1):
  - If stk_cnt>0: {zf,cf,nf} are loaded from the top entry and stk_cnt decrements.
  - If stk_cnt=0: the flags hold and unf_err is set.
  - ALU writes, setc/clrc, branch clear and int_save are all ignored that cycle.
- **Normal update**: next flags are computed from the current flags in this order, with later steps winning.
  1. ALU write: each flag whose flag_we bit is 1 takes the matching alu_* value.
  2. cf: setc forces 1, clrc forces 0. If both are asserted, clrc wins.
  3. Branch clear: if br_taken=1, the flag named by br_sel is cleared (00→zf, 01→cf, 10→nf). br_sel=11 clears nothing. The clear overrides steps 1–2 for that flag.
- **Save** (int_save=1, no restore):
  - The pushed value is the current registered {zf,cf,nf}, i.e. the value before this cycle's update. The normal update still applies in the same cycle.
  - If stk_cnt=DEPTH: no push, stk_cnt holds, and ovf_err is set.
- Error flags are sticky; only reset clears them.
- The stack is LIFO, so nested interrupts restore in reverse order.

## Timing
- All outputs are registered. Any update is visible on zf/cf/nf one cycle after the qualifying edge.
- No combinational path exists from any input to zf/cf/nf. The flag → branch_out → br_taken loop is therefore broken by this register.
- The branch-clear effect appears one cycle after the cycle in which br_taken=1 was sampled.
- stk_cnt changes on the same edge as the push or pop.
- A save in cycle N followed by a restore in cycle N+1 returns the flags exactly as they were before cycle N.
- Wrap-around: stk_cnt saturates at 0 and at DEPTH; it never wraps.

## Test plan
- Reset then update:
  - Stimulus: drive random inputs with rst_n=0 for 2 cycles, then release. Apply flag_we=111 with alu={1,1,1} for one cycle.
  - Required: all outputs are 0 during reset; zf=cf=nf=1 one cycle after the write.
- Masked write and cf forcing:
  - Stimulus: from flags 000, apply flag_we=101 with alu={1,1,1} and setc=1, clrc=1 in the same cycle.
  - Required: zf=1, nf=1, cf=0 (clrc wins).
- Branch clear:
  - Stimulus: from flags 111, apply br_taken=1, br_sel=00 together with flag_we=100, alu_zf=1.
  - Required: zf=0, cf=1, nf=1.
  - Stimulus: repeat with br_sel=11.
  - Required: flags unchanged at 111.
- Nested save/restore with DEPTH=2:
  - Stimulus: with flags=100 save; set flags 010 and save; set flags 001 and save; then restore 3 times.
  - Required: the 3rd save sets ovf_err=1 and leaves stk_cnt=2. The restores yield 010, then 100. The 3rd restore holds 100 and sets unf_err=1.
- Save plus update in one cycle:
  - Stimulus: flags=000; assert int_save=1 with flag_we=010, alu_cf=1; then restore.
  - Required: cf=1 after the first cycle; flags return to 000 after the restore.
- Stall:
  - Stimulus: assert stall=1 with int_save, int_restore, br_taken and flag_we=111 all active for 3 cycles.
  - Required: flags, stk_cnt and both error flags are unchanged.
  - Stimulus: assert rst_n=0 while stall=1.
  - Required: reset values are loaded.
